// File: rtl/mvp_test_sequencer.sv
// Test sequencer: launches one operation on a module under test from register-bank
// writes, waits for completion or timeout, and exposes result, cycle count and status.
module mvp_test_sequencer #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  cfg_wr_valid,
  input  logic [1:0]            cfg_wr_addr,
  input  logic [DATA_WIDTH-1:0] cfg_wr_data,
  input  logic [1:0]            stat_rd_addr,
  output logic [DATA_WIDTH-1:0] stat_rd_data,
  output logic                  mut_start,
  output logic [DATA_WIDTH-1:0] mut_opa,
  output logic [DATA_WIDTH-1:0] mut_opb,
  input  logic                  mut_done,
  input  logic [DATA_WIDTH-1:0] mut_result,
  output logic                  irq
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LAUNCH  = 2'd1,
    ST_WAIT    = 2'd2,
    ST_CAPTURE = 2'd3
  } state_t;

  localparam logic [15:0] L_TIMEOUT = 16'(TIMEOUT_CYCLES);

  state_t                r_state;
  state_t                w_next_state;
  logic [DATA_WIDTH-1:0] r_sh_a;
  logic [DATA_WIDTH-1:0] r_sh_b;
  logic [DATA_WIDTH-1:0] r_opa;
  logic [DATA_WIDTH-1:0] r_opb;
  logic [DATA_WIDTH-1:0] r_cap_result;
  logic [DATA_WIDTH-1:0] r_result;
  logic [DATA_WIDTH-1:0] r_cycles;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic [DATA_WIDTH-1:0] w_rd_mux;
  logic [DATA_WIDTH-1:0] w_status;
  logic [15:0]           r_wait_cnt;
  logic [15:0]           r_cap_cycles;
  logic [31:0]           r_run_count;
  logic                  r_done;
  logic                  r_timeout;
  logic                  r_overrun;
  logic                  r_irq_en;
  logic                  r_irq;
  logic                  r_mut_start;
  logic                  w_ctrl_wr;
  logic                  w_start_wr;
  logic                  w_clear_wr;
  logic                  w_busy;
  logic                  w_launch;
  logic                  w_timeout_hit;
  logic                  w_capture;

  assign w_ctrl_wr     = cfg_wr_valid && (cfg_wr_addr == 2'd0);
  assign w_start_wr    = w_ctrl_wr && cfg_wr_data[0];
  assign w_clear_wr    = w_ctrl_wr && cfg_wr_data[1];
  assign w_busy        = (r_state != ST_IDLE);
  assign w_capture     = (r_state == ST_CAPTURE);
  // A completion on the last allowed cycle takes priority over the timeout.
  assign w_timeout_hit = (r_state == ST_WAIT) && !mut_done && (r_wait_cnt == L_TIMEOUT);

  // State register.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode and launch strobe.
  always_comb begin
    w_next_state = r_state;
    w_launch     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_wr) begin
          w_next_state = ST_LAUNCH;
          w_launch     = 1'b1;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_LAUNCH: w_next_state = ST_WAIT;
      ST_WAIT: begin
        if (mut_done) begin
          w_next_state = ST_CAPTURE;
        end else if (w_timeout_hit) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_WAIT;
        end
      end
      ST_CAPTURE: w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  // Readback multiplexer.
  always_comb begin
    w_status      = '0;
    w_status[4:0] = {r_irq_en, r_overrun, r_timeout, r_done, w_busy};
    case (stat_rd_addr)
      2'd0:    w_rd_mux = w_status;
      2'd1:    w_rd_mux = r_result;
      2'd2:    w_rd_mux = r_cycles;
      2'd3:    w_rd_mux = DATA_WIDTH'(r_run_count);
      default: w_rd_mux = '0;
    endcase
  end

  // Datapath, status flags and registered outputs.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_sh_a       <= '0;
      r_sh_b       <= '0;
      r_opa        <= '0;
      r_opb        <= '0;
      r_cap_result <= '0;
      r_result     <= '0;
      r_cycles     <= '0;
      r_rd_data    <= '0;
      r_wait_cnt   <= 16'd0;
      r_cap_cycles <= 16'd0;
      r_run_count  <= 32'd0;
      r_done       <= 1'b0;
      r_timeout    <= 1'b0;
      r_overrun    <= 1'b0;
      r_irq_en     <= 1'b0;
      r_irq        <= 1'b0;
      r_mut_start  <= 1'b0;
    end else begin
      r_mut_start <= w_launch;
      r_rd_data   <= w_rd_mux;
      r_irq       <= r_irq_en & (r_done | r_timeout);
      if (cfg_wr_valid && (cfg_wr_addr == 2'd1)) r_sh_a <= cfg_wr_data;
      if (cfg_wr_valid && (cfg_wr_addr == 2'd2)) r_sh_b <= cfg_wr_data;
      if (w_ctrl_wr) r_irq_en <= cfg_wr_data[2];
      if (w_launch) begin
        r_opa <= r_sh_a;
        r_opb <= r_sh_b;
      end
      if (r_state == ST_LAUNCH) begin
        r_wait_cnt <= 16'd1;
      end else if ((r_state == ST_WAIT) && !mut_done && !w_timeout_hit) begin
        r_wait_cnt <= r_wait_cnt + 16'd1;
      end
      if ((r_state == ST_WAIT) && mut_done) begin
        r_cap_result <= mut_result;
        r_cap_cycles <= r_wait_cnt;
      end
      if (w_capture) begin
        r_result    <= r_cap_result;
        r_cycles    <= DATA_WIDTH'(r_cap_cycles);
        r_run_count <= r_run_count + 32'd1;
      end
      // Setting a flag wins over a simultaneous CLEAR.
      if (w_capture) begin
        r_done <= 1'b1;
      end else if (w_clear_wr || w_launch) begin
        r_done <= 1'b0;
      end
      if (w_timeout_hit) begin
        r_timeout <= 1'b1;
      end else if (w_clear_wr || w_launch) begin
        r_timeout <= 1'b0;
      end
      if (w_start_wr && w_busy) begin
        r_overrun <= 1'b1;
      end else if (w_clear_wr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign stat_rd_data = r_rd_data;
  assign mut_start    = r_mut_start;
  assign mut_opa      = r_opa;
  assign mut_opb      = r_opb;
  assign irq          = r_irq;

endmodule

// File: tb/tb_mvp_test_sequencer.sv
// Bench for mvp_test_sequencer: directed and randomized runs checked against a
// run-level reference model of the register map and status flags.
module tb_mvp_test_sequencer;

  localparam int DW  = 32;
  localparam int TMO = 1000;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic          cfg_wr_valid;
  logic [1:0]    cfg_wr_addr;
  logic [DW-1:0] cfg_wr_data;
  logic [1:0]    stat_rd_addr;
  logic [DW-1:0] stat_rd_data;
  logic          mut_start;
  logic [DW-1:0] mut_opa;
  logic [DW-1:0] mut_opb;
  logic          mut_done;
  logic [DW-1:0] mut_result;
  logic          irq;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] m_sh_a, m_sh_b, m_opa, m_opb, m_result, m_cycles, m_runs;
  bit          m_done, m_tmo, m_ovr, m_irqen;

  always #5 ACLK = ~ACLK;

  mvp_test_sequencer #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cfg_wr_valid(cfg_wr_valid), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
    .stat_rd_addr(stat_rd_addr), .stat_rd_data(stat_rd_data),
    .mut_start(mut_start), .mut_opa(mut_opa), .mut_opb(mut_opb),
    .mut_done(mut_done), .mut_result(mut_result), .irq(irq)
  );

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    return {27'd0, m_irqen, m_ovr, m_tmo, m_done, 1'b0};
  endfunction

  task automatic model_reset();
    m_sh_a = 32'd0; m_sh_b = 32'd0; m_opa = 32'd0; m_opb = 32'd0;
    m_result = 32'd0; m_cycles = 32'd0; m_runs = 32'd0;
    m_done = 1'b0; m_tmo = 1'b0; m_ovr = 1'b0; m_irqen = 1'b0;
  endtask

  task automatic wr(input logic [1:0] addr, input logic [31:0] data);
    cfg_wr_valid = 1'b1;
    cfg_wr_addr  = addr;
    cfg_wr_data  = data;
    if (addr == 2'd1) m_sh_a = data;
    if (addr == 2'd2) m_sh_b = data;
    tick();
    cfg_wr_valid = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [1:0] addr, input logic [31:0] exp);
    stat_rd_addr = addr;
    tick();
    chk(tag, stat_rd_data, exp);
  endtask

  task automatic check_all(input string tag);
    rd({tag, ".status"}, 2'd0, m_status());
    rd({tag, ".result"}, 2'd1, m_result);
    rd({tag, ".cycles"}, 2'd2, m_cycles);
    rd({tag, ".runs"},   2'd3, m_runs);
    chk({tag, ".irq"}, {31'd0, irq}, {31'd0, m_irqen & (m_done | m_tmo)});
    chk({tag, ".opa"}, mut_opa, m_opa);
    chk({tag, ".opb"}, mut_opb, m_opb);
  endtask

  // One complete run. done_at = WAIT cycle of mut_done (0 = never).
  // inj: 0 none, 1 START during WAIT cycle 1, 2 OPA write during WAIT cycle 1.
  task automatic do_run(input string tag, input bit wr_ops, input logic [31:0] a,
                        input logic [31:0] b, input bit irqen, input bit clr_first,
                        input int done_at, input logic [31:0] res, input int inj,
                        input bit clr_cap);
    bit hit;
    if (wr_ops) begin
      wr(2'd1, a);
      wr(2'd2, b);
    end
    cfg_wr_valid = 1'b1;
    cfg_wr_addr  = 2'd0;
    cfg_wr_data  = {29'd0, irqen, clr_first, 1'b1};
    tick();
    cfg_wr_valid = 1'b0;
    if (clr_first) m_ovr = 1'b0;
    m_done = 1'b0; m_tmo = 1'b0; m_irqen = irqen;
    m_opa = m_sh_a; m_opb = m_sh_b;
    chk({tag, ".start_hi"}, {31'd0, mut_start}, 32'd1);
    chk({tag, ".launch_opa"}, mut_opa, m_opa);
    chk({tag, ".launch_opb"}, mut_opb, m_opb);
    tick();
    hit = 1'b0;
    for (int k = 1; k <= TMO; k++) begin
      chk({tag, ".start_lo"}, {31'd0, mut_start}, 32'd0);
      cfg_wr_valid = 1'b0;
      mut_done = 1'b0;
      if (k == 1 && inj == 1) begin
        cfg_wr_valid = 1'b1; cfg_wr_addr = 2'd0; cfg_wr_data = {29'd0, m_irqen, 2'b01};
        m_ovr = 1'b1;
      end
      if (k == 1 && inj == 2) begin
        cfg_wr_valid = 1'b1; cfg_wr_addr = 2'd1; cfg_wr_data = $urandom;
        m_sh_a = cfg_wr_data;
      end
      if (k == done_at) begin
        mut_done = 1'b1;
        mut_result = res;
      end
      tick();
      cfg_wr_valid = 1'b0;
      mut_done = 1'b0;
      mut_result = $urandom;
      if (k == done_at) begin
        hit = 1'b1;
        break;
      end
    end
    if (hit) begin
      if (clr_cap) begin
        cfg_wr_valid = 1'b1; cfg_wr_addr = 2'd0; cfg_wr_data = {29'd0, m_irqen, 2'b10};
        m_ovr = 1'b0;
      end
      tick();
      cfg_wr_valid = 1'b0;
      m_done = 1'b1; m_result = res; m_cycles = done_at; m_runs = m_runs + 32'd1;
    end else begin
      m_tmo = 1'b1;
    end
    check_all(tag);
  endtask

  initial begin
    ARESET = 1'b1; cfg_wr_valid = 1'b0; cfg_wr_addr = 2'd0; cfg_wr_data = '0;
    stat_rd_addr = 2'd0; mut_done = 1'b0; mut_result = '0;
    model_reset();
    tick(); tick();
    chk("rst.start", {31'd0, mut_start}, 32'd0);
    chk("rst.irq", {31'd0, irq}, 32'd0);
    chk("rst.rd", stat_rd_data, 32'd0);
    ARESET = 1'b0;
    check_all("rst");

    // Directed: launch operands and 4-cycle completion
    do_run("basic", 1'b1, 32'h5, 32'h3, 1'b0, 1'b0, 4, 32'hA, 0, 1'b0);
    // Timeout with interrupt enabled, then CLEAR drops irq
    do_run("tmo", 1'b1, 32'h11, 32'h22, 1'b1, 1'b0, 0, 32'h0, 0, 1'b0);
    wr(2'd0, 32'h6);
    m_done = 1'b0; m_tmo = 1'b0; m_ovr = 1'b0;
    check_all("tmo_clr");
    // Overrun during WAIT, then CLEAR+START launches immediately
    do_run("ovr", 1'b1, 32'h33, 32'h44, 1'b1, 1'b0, 6, 32'hBEEF, 1, 1'b0);
    do_run("clrstart", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 2, 32'h1234, 0, 1'b0);
    // Completion on the last allowed WAIT cycle
    do_run("edge", 1'b1, 32'h77, 32'h88, 1'b0, 1'b0, TMO, 32'hCAFE, 0, 1'b0);
    // CLEAR during CAPTURE: done still set
    do_run("clrcap", 1'b1, 32'h9, 32'h8, 1'b1, 1'b0, 3, 32'h5A, 1, 1'b1);

    // Randomized runs
    for (int r = 0; r < 10; r++) begin
      do_run("rand", 1'($urandom_range(0, 1)), $urandom, $urandom,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             int'($urandom_range(1, 20)), $urandom, int'($urandom_range(0, 2)),
             1'($urandom_range(0, 1)));
    end

    // Reset during WAIT, then a stray completion
    wr(2'd1, 32'hAB);
    wr(2'd0, 32'h5);
    tick(); tick(); tick();
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
    model_reset();
    mut_done = 1'b1; mut_result = 32'h55;
    tick();
    mut_done = 1'b0;
    chk("midrst.start", {31'd0, mut_start}, 32'd0);
    tick();
    check_all("midrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
